// File: rtl/mc_ctr_pkg.sv
// mc_ctr_pkg: shared state/class enums, MIPS opcode/funct constants and control encodings for mc_ctr
package mc_ctr_pkg;

    typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT} state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL, C_ILL
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_31 = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic [1:0] npc_sel;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       extop;
        logic       alusrc;
        logic [1:0] alu;
        logic       memrd;
        logic       memwr;
        logic       iord;
    } ctl_t;

endpackage

// File: rtl/mc_ctr_dec.sv
// mc_ctr_dec: combinational opcode/funct to instruction-class decoder
module mc_ctr_dec
    import mc_ctr_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls
);

    always_comb begin
        cls = C_ILL;
        case (opcode)
            OP_RTYPE: cls = funct == FN_ADDU ? C_ADDU : funct == FN_SUBU ? C_SUBU : C_ILL;
            OP_ORI:   cls = C_ORI;
            OP_LW:    cls = C_LW;
            OP_SW:    cls = C_SW;
            OP_BEQ:   cls = C_BEQ;
            OP_LUI:   cls = C_LUI;
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            default:  cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctr.sv
// mc_ctr: multi-cycle MIPS control FSM with memory-ready handshake, timeout and illegal-opcode traps.
// Define MC_CTR_PERF_EN to add the cyc_cnt/ins_cnt performance counters.
module mc_ctr
    import mc_ctr_pkg::*;
#(
    parameter int ALUCTR_W = 2,
    parameter int MEM_WAIT = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcwr,
    output logic                irwr,
    output logic [1:0]          npc_sel,
    output logic                regwr,
    output logic [1:0]          regdst,
    output logic [1:0]          memtoreg,
    output logic                extop,
    output logic                alusrc,
    output logic [ALUCTR_W-1:0] aluctr,
    output logic                memrd,
    output logic                memwr,
    output logic                iord,
    output logic                err_ill,
`ifdef MC_CTR_PERF_EN
    output logic [31:0]         cyc_cnt,
    output logic [31:0]         ins_cnt,
`endif
    output logic                err_tmo
);

    localparam int TW = $clog2(TIMEOUT + 2);

    state_t        state, state_n;
    cls_t          cls_q, cls_d;
    ctl_t          ctl;
    logic [TW-1:0] tmo_cnt;
    logic          mem_ok, waiting, tmo_hit;

    mc_ctr_dec u_dec (.opcode(opcode), .funct(funct), .cls(cls_d));

    assign mem_ok  = MEM_WAIT == 0 || mem_ready;
    assign waiting = (state == S_IF || state == S_MEM) && !mem_ok;
    // mem_ready on the limit cycle wins because waiting is already false then
    assign tmo_hit = TIMEOUT != 0 && waiting && (32'(tmo_cnt) + 1 == TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IF;
            cls_q   <= C_ADDU;
            tmo_cnt <= '0;
            err_ill <= 1'b0;
            err_tmo <= 1'b0;
        end else begin
            state   <= state_n;
            if (state == S_ID)
                cls_q <= cls_d;
            tmo_cnt <= state_n != state ? '0 : (waiting && TIMEOUT != 0) ? tmo_cnt + 1'b1 : tmo_cnt;
            err_ill <= err_ill | (state == S_ID && cls_d == C_ILL);
            err_tmo <= err_tmo | tmo_hit;
        end
    end

    always_comb begin
        state_n = state;
        ctl     = '0;
        case (state)
            S_IF: begin
                ctl.memrd = 1'b1;
                if (mem_ok) begin
                    ctl.irwr    = 1'b1;
                    ctl.pcwr    = 1'b1;
                    ctl.npc_sel = NPC_PC4;
                    state_n     = S_ID;
                end else if (tmo_hit) begin
                    state_n = S_HALT;
                end
            end
            // jumps resolve here from the live decode, before the class register updates
            S_ID: begin
                case (cls_d)
                    C_J, C_JAL: begin
                        ctl.pcwr    = 1'b1;
                        ctl.npc_sel = NPC_J;
                        state_n     = S_IF;
                        if (cls_d == C_JAL) begin
                            ctl.regwr    = 1'b1;
                            ctl.regdst   = DST_31;
                            ctl.memtoreg = M2R_PC4;
                        end
                    end
                    C_ILL:   state_n = S_HALT;
                    default: state_n = S_EXE;
                endcase
            end
            S_EXE: begin
                ctl.alusrc = cls_q inside {C_ORI, C_LUI, C_LW, C_SW};
                ctl.extop  = cls_q inside {C_LW, C_SW};
                ctl.alu    = cls_q inside {C_SUBU, C_BEQ} ? ALU_SUB :
                             cls_q == C_ORI ? ALU_OR : cls_q == C_LUI ? ALU_LUI : ALU_ADD;
                if (cls_q == C_BEQ) begin
                    ctl.npc_sel = NPC_BR;
                    ctl.pcwr    = zero;
                end
                state_n = cls_q == C_BEQ ? S_IF : cls_q inside {C_LW, C_SW} ? S_MEM : S_WB;
            end
            S_MEM: begin
                ctl.iord  = 1'b1;
                ctl.memrd = cls_q == C_LW;
                ctl.memwr = cls_q == C_SW;
                if (mem_ok)
                    state_n = cls_q == C_LW ? S_WB : S_IF;
                else if (tmo_hit)
                    state_n = S_HALT;
            end
            S_WB: begin
                ctl.regwr    = 1'b1;
                ctl.regdst   = cls_q inside {C_ADDU, C_SUBU} ? DST_RD : DST_RT;
                ctl.memtoreg = cls_q == C_LW ? M2R_MEM : M2R_ALU;
                state_n      = S_IF;
            end
            default: state_n = S_HALT;
        endcase
        if (reset)
            ctl = '0;
    end

    assign pcwr     = ctl.pcwr;
    assign irwr     = ctl.irwr;
    assign npc_sel  = ctl.npc_sel;
    assign regwr    = ctl.regwr;
    assign regdst   = ctl.regdst;
    assign memtoreg = ctl.memtoreg;
    assign extop    = ctl.extop;
    assign alusrc   = ctl.alusrc;
    assign aluctr   = ALUCTR_W'(ctl.alu);
    assign memrd    = ctl.memrd;
    assign memwr    = ctl.memwr;
    assign iord     = ctl.iord;

`ifdef MC_CTR_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (state != S_HALT)
                cyc_cnt <= cyc_cnt + 32'd1;
            if (state_n == S_IF && state != S_IF)
                ins_cnt <= ins_cnt + 32'd1;
        end
    end
`endif

endmodule
